// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I controller.
`default_nettype none

package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_J    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_I, OP_JALR: imm_sel = IMM_I;
            OP_STORE:               imm_sel = IMM_S;
            OP_BRANCH:              imm_sel = IMM_B;
            OP_JAL:                 imm_sel = IMM_J;
            OP_LUI, OP_AUIPC:       imm_sel = IMM_U;
            default:                imm_sel = IMM_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// alu_decoder: maps the controller's ALU request and instruction funct fields to an ALU operation code.
`default_nettype none

module alu_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUC_W = 4
) (
    input  logic [6:0]        op_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7b5_i,
    input  aluop_t            aluop_i,
    output logic [ALUC_W-1:0] alucontrol_o
);

    logic       is_r;
    logic [3:0] alu;

    // In I-type, IR[30] is an immediate bit, so it only selects SUB for R-type.
    assign is_r = (op_i == OP_R);

    always_comb begin
        alu = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alu = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu = (is_r && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu = ALU_SLL;
                    3'b010:  alu = ALU_SLT;
                    3'b011:  alu = ALU_SLTU;
                    3'b100:  alu = ALU_XOR;
                    3'b101:  alu = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu = ALU_OR;
                    default: alu = ALU_AND;
                endcase
            end
            default: alu = ALU_ADD;
        endcase
    end

    assign alucontrol_o = ALUC_W'(alu);

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RV32I datapath,
// with memory wait handshake and a sticky illegal-instruction trap.
`default_nettype none

module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int ALUC_W          = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              zero,
    input  logic              lt,
    input  logic              ltu,
    input  logic              mem_ready,
    output logic [2:0]        immsrc,
    output logic [1:0]        alusrca,
    output logic [1:0]        alusrcb,
    output logic [ALUC_W-1:0] alucontrol,
    output logic [1:0]        resultsrc,
    output logic              adrsrc,
    output logic              irwrite,
    output logic              pcwrite,
    output logic              regwrite,
    output logic              memwrite,
    output logic              illegal,
    output logic              retire
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   ir_raw, pc_raw, rw_raw, mw_raw, ill_raw, ret_raw;
    logic   br_taken, br_legal;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        br_taken = 1'b0;
        br_legal = 1'b1;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        resultsrc = RES_ALUOUT;
        adrsrc    = 1'b0;
        aluop     = ALUOP_ADD;
        ir_raw    = 1'b0;
        pc_raw    = 1'b0;
        rw_raw    = 1'b0;
        mw_raw    = 1'b0;
        ill_raw   = 1'b0;
        ret_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                ir_raw    = mem_ready;
                pc_raw    = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d = S_TRAP;
                        end else begin
                            state_d = S_FETCH;
                            ret_raw = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc = RES_MEMDATA;
                rw_raw    = 1'b1;
                ret_raw   = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc  = 1'b1;
                mw_raw  = 1'b1;
                ret_raw = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = (state_q == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rw_raw  = 1'b1;
                ret_raw = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_SUB;
                if (!br_legal && TRAP_ON_ILLEGAL) begin
                    state_d = S_TRAP;
                end else begin
                    pc_raw  = br_taken && br_legal;
                    ret_raw = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_JALR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                state_d = S_JAL;
            end
            // Loads the PC from ALUOut while the ALU forms the link value OldPC+4.
            S_JAL: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_FOUR;
                pc_raw  = 1'b1;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                alusrca = SRCA_ZERO;
                alusrcb = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                ill_raw = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign immsrc = imm_sel(op);

    // Qualify with reset so an access in flight is dropped immediately.
    assign irwrite  = ir_raw  & resetn;
    assign pcwrite  = pc_raw  & resetn;
    assign regwrite = rw_raw  & resetn;
    assign memwrite = mw_raw  & resetn;
    assign illegal  = ill_raw & resetn;
    assign retire   = ret_raw & resetn;

    alu_decoder #(
        .ALUC_W(ALUC_W)
    ) u_alu_decoder (
        .op_i        (op),
        .funct3_i    (funct3),
        .funct7b5_i  (funct7b5),
        .aluop_i     (aluop),
        .alucontrol_o(alucontrol)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors queued as expected outputs, checked by a separate monitor.
`default_nettype none

module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [6:0] op = 7'h33;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic       mem_ready = 1'b1;

    logic [6:0] s_op = 7'h33;
    logic [2:0] s_f3 = 3'b000;
    logic       s_f7 = 1'b0, s_zero = 1'b0, s_lt = 1'b0, s_ltu = 1'b0;

    logic [2:0] immsrc, immsrc0;
    logic [1:0] alusrca, alusrcb, resultsrc, alusrca0, alusrcb0, resultsrc0;
    logic [3:0] alucontrol, alucontrol0;
    logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal, retire;
    logic       adrsrc0, irwrite0, pcwrite0, regwrite0, memwrite0, illegal0, retire0;

    always #5 clk = ~clk;

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1), .ALUC_W(4)) dut (
        .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .resultsrc(resultsrc), .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite),
        .regwrite(regwrite), .memwrite(memwrite), .illegal(illegal), .retire(retire)
    );

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0), .ALUC_W(4)) dut0 (
        .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .immsrc(immsrc0), .alusrca(alusrca0), .alusrcb(alusrcb0), .alucontrol(alucontrol0),
        .resultsrc(resultsrc0), .adrsrc(adrsrc0), .irwrite(irwrite0), .pcwrite(pcwrite0),
        .regwrite(regwrite0), .memwrite(memwrite0), .illegal(illegal0), .retire(retire0)
    );

    logic [19:0] act, act0;
    assign act  = {immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
                   irwrite, pcwrite, regwrite, memwrite, illegal, retire};
    assign act0 = {immsrc0, alusrca0, alusrcb0, alucontrol0, resultsrc0, adrsrc0,
                   irwrite0, pcwrite0, regwrite0, memwrite0, illegal0, retire0};

    // Strobe groups: {irwrite, pcwrite, regwrite, memwrite, illegal, retire}
    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] IRPC  = 6'b110000;
    localparam logic [5:0] PCW   = 6'b010000;
    localparam logic [5:0] RWRET = 6'b001001;
    localparam logic [5:0] MW    = 6'b000100;
    localparam logic [5:0] MWRET = 6'b000101;
    localparam logic [5:0] ILL   = 6'b000010;
    localparam logic [5:0] RET   = 6'b000001;
    localparam logic [5:0] PCRET = 6'b010001;

    typedef struct {
        string       name;
        logic [19:0] exp;
        bit          chk0;
        logic [19:0] exp0;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [19:0] ev(input logic [2:0] imm, input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] alu, input logic [1:0] res, input logic adr,
                                       input logic [5:0] s);
        return {imm, a, b, alu, res, adr, s};
    endfunction

    function automatic logic [19:0] fF(input logic [2:0] imm, input logic [5:0] s);
        return ev(imm, 2'b00, 2'b10, ALU_ADD, 2'b10, 1'b0, s);
    endfunction

    function automatic logic [19:0] fD(input logic [2:0] imm);
        return ev(imm, 2'b01, 2'b01, ALU_ADD, 2'b00, 1'b0, NONE);
    endfunction

    function automatic logic [19:0] fWB(input logic [2:0] imm);
        return ev(imm, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b0, RWRET);
    endfunction

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        s_op = o; s_f3 = f3; s_f7 = f7;
    endtask

    task automatic set_flags(input logic z, input logic l, input logic lu);
        s_zero = z; s_lt = l; s_ltu = lu;
    endtask

    task automatic step0(input string nm, input logic rn, input logic mr, input logic [19:0] e,
                         input bit c0, input logic [19:0] e0);
        exp_t x;
        @(posedge clk);
        #1;
        resetn = rn; mem_ready = mr;
        op = s_op; funct3 = s_f3; funct7b5 = s_f7;
        zero = s_zero; lt = s_lt; ltu = s_ltu;
        x.name = nm; x.exp = e; x.chk0 = c0; x.exp0 = e0;
        q.push_back(x);
    endtask

    task automatic step(input string nm, input logic rn, input logic mr, input logic [19:0] e);
        step0(nm, rn, mr, e, 1'b0, 20'h0);
    endtask

    task automatic instr4(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [2:0] imm, input logic [1:0] a, input logic [1:0] b,
                          input logic [3:0] alu);
        set_ir(o, f3, f7);
        step({nm, "_fetch"}, 1'b1, 1'b1, fF(imm, IRPC));
        step({nm, "_decode"}, 1'b1, 1'b1, fD(imm));
        step({nm, "_exec"}, 1'b1, 1'b1, ev(imm, a, b, alu, 2'b00, 1'b0, NONE));
        step({nm, "_wb"}, 1'b1, 1'b1, fWB(imm));
    endtask

    task automatic branch(input string nm, input logic [2:0] f3, input logic z, input logic l,
                          input logic lu, input logic taken);
        set_ir(7'h63, f3, 1'b0);
        set_flags(z, l, lu);
        step({nm, "_fetch"}, 1'b1, 1'b1, fF(3'b010, IRPC));
        step({nm, "_decode"}, 1'b1, 1'b1, fD(3'b010));
        step({nm, "_br"}, 1'b1, 1'b1, ev(3'b010, 2'b10, 2'b00, ALU_SUB, 2'b00, 1'b0, taken ? PCRET : RET));
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (act !== x.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
                end
                if (x.chk0) begin
                    checks++;
                    if (act0 !== x.exp0) begin
                        errors++;
                        $display("FAIL %s(nontrap): got %h expected %h", x.name, act0, x.exp0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        // Reset held in FETCH with mem_ready high: no strobes.
        step("rst_fetch0", 1'b0, 1'b1, fF(3'b111, NONE));
        step("rst_fetch1", 1'b0, 1'b1, fF(3'b111, NONE));
        step("fetch_wait", 1'b1, 1'b0, fF(3'b111, NONE));

        instr4("add",  7'h33, 3'b000, 1'b0, 3'b111, 2'b10, 2'b00, ALU_ADD);
        instr4("sub",  7'h33, 3'b000, 1'b1, 3'b111, 2'b10, 2'b00, ALU_SUB);
        instr4("slt",  7'h33, 3'b010, 1'b0, 3'b111, 2'b10, 2'b00, ALU_SLT);
        instr4("sra",  7'h33, 3'b101, 1'b1, 3'b111, 2'b10, 2'b00, ALU_SRA);
        instr4("addi", 7'h13, 3'b000, 1'b1, 3'b000, 2'b10, 2'b01, ALU_ADD);
        instr4("srai", 7'h13, 3'b101, 1'b1, 3'b000, 2'b10, 2'b01, ALU_SRA);
        instr4("srli", 7'h13, 3'b101, 1'b0, 3'b000, 2'b10, 2'b01, ALU_SRL);
        instr4("sltiu",7'h13, 3'b011, 1'b0, 3'b000, 2'b10, 2'b01, ALU_SLTU);
        instr4("lui",  7'h37, 3'b000, 1'b0, 3'b100, 2'b11, 2'b01, ALU_ADD);
        instr4("auipc",7'h17, 3'b000, 1'b0, 3'b100, 2'b01, 2'b01, ALU_ADD);

        // sw with a fetch wait and three memory wait states
        set_ir(7'h23, 3'b010, 1'b0);
        step("sw_fetch_wait", 1'b1, 1'b0, fF(3'b001, NONE));
        step("sw_fetch", 1'b1, 1'b1, fF(3'b001, IRPC));
        step("sw_decode", 1'b1, 1'b1, fD(3'b001));
        step("sw_memadr", 1'b1, 1'b1, ev(3'b001, 2'b10, 2'b01, ALU_ADD, 2'b00, 1'b0, NONE));
        for (int i = 0; i < 3; i++)
            step("sw_memwrite_wait", 1'b1, 1'b0, ev(3'b001, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b1, MW));
        step("sw_memwrite_done", 1'b1, 1'b1, ev(3'b001, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b1, MWRET));

        // lw with one memory wait state
        set_ir(7'h03, 3'b010, 1'b0);
        step("lw_fetch", 1'b1, 1'b1, fF(3'b000, IRPC));
        step("lw_decode", 1'b1, 1'b1, fD(3'b000));
        step("lw_memadr", 1'b1, 1'b1, ev(3'b000, 2'b10, 2'b01, ALU_ADD, 2'b00, 1'b0, NONE));
        step("lw_memread_wait", 1'b1, 1'b0, ev(3'b000, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b1, NONE));
        step("lw_memread_done", 1'b1, 1'b1, ev(3'b000, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b1, NONE));
        step("lw_memwb", 1'b1, 1'b1, ev(3'b000, 2'b00, 2'b00, ALU_ADD, 2'b01, 1'b0, RWRET));

        // sw interrupted by reset mid-access: memwrite drops in the same cycle
        set_ir(7'h23, 3'b010, 1'b0);
        step("swr_fetch", 1'b1, 1'b1, fF(3'b001, IRPC));
        step("swr_decode", 1'b1, 1'b1, fD(3'b001));
        step("swr_memadr", 1'b1, 1'b1, ev(3'b001, 2'b10, 2'b01, ALU_ADD, 2'b00, 1'b0, NONE));
        step("swr_memwrite", 1'b1, 1'b0, ev(3'b001, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b1, MW));
        step("swr_reset", 1'b0, 1'b0, fF(3'b001, NONE));
        step("swr_release", 1'b1, 1'b0, fF(3'b001, NONE));

        branch("bne_eq",  3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        branch("bne_ne",  3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        branch("beq_eq",  3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        branch("blt_lt",  3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        branch("bge_lt",  3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
        branch("bltu_ge", 3'b110, 1'b0, 1'b1, 1'b0, 1'b0);
        branch("bgeu_ge", 3'b111, 1'b0, 1'b1, 1'b0, 1'b1);
        set_flags(1'b0, 1'b0, 1'b0);

        // jalr 0x000080E7
        set_ir(7'h67, 3'b000, 1'b0);
        step("jalr_fetch", 1'b1, 1'b1, fF(3'b000, IRPC));
        step("jalr_decode", 1'b1, 1'b1, fD(3'b000));
        step("jalr_jalr", 1'b1, 1'b1, ev(3'b000, 2'b10, 2'b01, ALU_ADD, 2'b00, 1'b0, NONE));
        step("jalr_jal", 1'b1, 1'b1, ev(3'b000, 2'b01, 2'b10, ALU_ADD, 2'b00, 1'b0, PCW));
        step("jalr_wb", 1'b1, 1'b1, fWB(3'b000));

        set_ir(7'h6F, 3'b000, 1'b0);
        step("jal_fetch", 1'b1, 1'b1, fF(3'b011, IRPC));
        step("jal_decode", 1'b1, 1'b1, fD(3'b011));
        step("jal_jal", 1'b1, 1'b1, ev(3'b011, 2'b01, 2'b10, ALU_ADD, 2'b00, 1'b0, PCW));
        step("jal_wb", 1'b1, 1'b1, fWB(3'b011));

        // Unknown opcode: trap is sticky; the non-trapping variant returns to FETCH.
        set_ir(7'h7F, 3'b000, 1'b0);
        step("ill_fetch", 1'b1, 1'b1, fF(3'b111, IRPC));
        step("ill_decode", 1'b1, 1'b1, fD(3'b111));
        step0("ill_trap", 1'b1, 1'b1, ev(3'b111, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b0, ILL),
              1'b1, fF(3'b111, IRPC));
        for (int i = 1; i < 100; i++)
            step("ill_trap_hold", 1'b1, 1'b1, ev(3'b111, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b0, ILL));
        step0("ill_reset", 1'b0, 1'b1, fF(3'b111, NONE), 1'b1, fF(3'b111, NONE));
        instr4("post_trap_add", 7'h33, 3'b000, 1'b0, 3'b111, 2'b10, 2'b00, ALU_ADD);

        // Reserved branch funct3 traps
        set_ir(7'h63, 3'b010, 1'b0);
        step("brill_fetch", 1'b1, 1'b1, fF(3'b010, IRPC));
        step("brill_decode", 1'b1, 1'b1, fD(3'b010));
        step("brill_branch", 1'b1, 1'b1, ev(3'b010, 2'b10, 2'b00, ALU_SUB, 2'b00, 1'b0, NONE));
        step0("brill_trap", 1'b1, 1'b1, ev(3'b010, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b0, ILL),
              1'b1, fF(3'b010, IRPC));
        step("brill_reset", 1'b0, 1'b0, fF(3'b010, NONE));
        step("brill_release", 1'b1, 1'b0, fF(3'b010, NONE));

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
